// File: rtl/rgb_sram_frame_writer_pkg.sv
// Shared types for the RGB frame writer: FSM state encoding, pixel layout and SRAM bus widths.
package rgb_sram_frame_writer_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_RW_IDLE,
    S_RW_WAIT_P0,
    S_RW_WAIT_P1,
    S_RW_WR1,
    S_RW_WR2,
    S_RW_DONE
  } RGB_writer_state_type;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

endpackage

// File: rtl/rgb_sram_frame_writer.sv
// Accepts a raster-order stream of RGB pixels and writes each pixel pair as three 16-bit words
// to consecutive SRAM addresses starting at a per-frame base address.
//
// state        | meaning
// S_RW_IDLE    | waiting for start, SRAM bus released (we_n=1)
// S_RW_WAIT_P0 | waiting for the first pixel of a pair
// S_RW_WAIT_P1 | waiting for the second pixel; on transfer writes word0
// S_RW_WR1     | writes word1 {B0,R1}
// S_RW_WR2     | writes word2 {G1,B1}, advances the pair counter
// S_RW_DONE    | frame finished, pulses done
module rgb_sram_frame_writer
  import rgb_sram_frame_writer_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  input  logic [17:0] SRAM_base_address,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_R,
  input  logic [7:0]  pixel_G,
  input  logic [7:0]  pixel_B,
  output logic        pixel_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done
);

  localparam int NUM_PAIRS = IMAGE_WIDTH * IMAGE_HEIGHT / 2;
  localparam int CNT_W     = $clog2(NUM_PAIRS) + 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 1);

  RGB_writer_state_type state_q, state_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]       pair_cnt_q, pair_cnt_d;
  rgb_pixel_t             p0_q, p0_d;
  rgb_pixel_t             p1_q, p1_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic                   we_n_q, we_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  rgb_pixel_t             pix_in;
  logic                   transfer;
  logic [SRAM_ADDR_W-1:0] pair_offset;

  assign pixel_ready = (state_q == S_RW_WAIT_P0) || (state_q == S_RW_WAIT_P1);
  assign transfer    = pixel_valid && pixel_ready;
  assign pix_in      = {pixel_R, pixel_G, pixel_B};
  // Three words per pair, so pair k starts 3k words past the base; the sum wraps at 2^18.
  assign pair_offset = SRAM_ADDR_W'(pair_cnt_q) * SRAM_ADDR_W'(3);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    pair_cnt_d = pair_cnt_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_n_d     = we_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_RW_IDLE: begin
        we_n_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          base_d     = SRAM_base_address;
          pair_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = S_RW_WAIT_P0;
        end
      end
      S_RW_WAIT_P0: begin
        we_n_d = 1'b1;
        if (transfer) begin
          p0_d    = pix_in;
          state_d = S_RW_WAIT_P1;
        end
      end
      S_RW_WAIT_P1: begin
        we_n_d = 1'b1;
        if (transfer) begin
          addr_d  = base_q + pair_offset;
          wdata_d = {p0_q.r, p0_q.g};
          we_n_d  = 1'b0;
          p1_d    = pix_in;
          state_d = S_RW_WR1;
        end
      end
      S_RW_WR1: begin
        addr_d  = addr_q + SRAM_ADDR_W'(1);
        wdata_d = {p0_q.b, p1_q.r};
        we_n_d  = 1'b0;
        state_d = S_RW_WR2;
      end
      S_RW_WR2: begin
        addr_d     = addr_q + SRAM_ADDR_W'(1);
        wdata_d    = {p1_q.g, p1_q.b};
        we_n_d     = 1'b0;
        pair_cnt_d = pair_cnt_q + CNT_W'(1);
        state_d    = (pair_cnt_q == LAST_PAIR) ? S_RW_DONE : S_RW_WAIT_P0;
      end
      S_RW_DONE: begin
        we_n_d  = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_RW_IDLE;
      end
      default: begin
        we_n_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_RW_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_RW_IDLE;
      base_q     <= '0;
      pair_cnt_q <= '0;
      p0_q       <= '0;
      p1_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      pair_cnt_q <= pair_cnt_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_n_q     <= we_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
